// File: rtl/breakout_renderer.sv
// Breakout paddle/ball/score logic and pixel colour for the VGA timing chain; optional brick row with `define BRICKS_EN.
// Game state moves on the frame tick (hor 0, line 480) only; rgb_out is registered 1 cycle after hor/ver; no backpressure.
module breakout_renderer #(
    parameter int PADDLE_W     = 64,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int START_LIVES  = 3,
    parameter int LOST_FRAMES  = 32
) (
    input  logic       CLK_25MH,
    input  logic       rst_n,
    input  logic [9:0] hor_count,
    input  logic [9:0] ver_count,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_serve,
    output logic [2:0] rgb_out,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic [1:0] game_state
);
    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_LOST  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [10:0] SCR_W    = 11'd640;
    localparam logic [10:0] SCR_H    = 11'd480;
    localparam logic [10:0] PAD_Y    = 11'd448;
    localparam logic [10:0] PAD_W    = 11'(PADDLE_W);
    localparam logic [10:0] BALL_W   = 11'(BALL_SIZE);
    localparam logic [10:0] BALL_SP  = 11'(BALL_SPEED);
    localparam logic [10:0] PAD_SP   = 11'(PADDLE_SPEED);
    localparam logic [10:0] PAD_MAX  = SCR_W - PAD_W;
    localparam logic [10:0] BALL_MAX = SCR_W - BALL_W;
    localparam logic [10:0] BALL_OFS = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [10:0] SERVE_Y  = PAD_Y - BALL_W;
    localparam logic [9:0]  PAD_X0   = 10'd288;
    localparam int          LCW      = $clog2(LOST_FRAMES + 1);
    localparam logic [LCW-1:0] LOST_LAST = LCW'(LOST_FRAMES - 1);

    state_t         state, state_nxt;
    logic [9:0]     paddle_x, paddle_x_nxt;
    logic [9:0]     ball_x, ball_x_nxt, ball_y, ball_y_nxt;
    logic           dx_right, dx_right_nxt, dy_up, dy_up_nxt;
    logic           dx_play, dy_play;
    logic [1:0]     lives_nxt;
    logic [7:0]     score_nxt;
    logic [LCW-1:0] lost_cnt, lost_cnt_nxt;
    logic           serve_prev, serve_prev_nxt;
    logic [2:0]     rgb_nxt;
    logic           tick, serve_edge, pad_hit, miss, in_ball, in_pad;
    logic [10:0]    px, bx, by, pad_mv, serve_x, nx, ny, hx, vy;
`ifdef BRICKS_EN
    logic [7:0]     brick_mask, brick_mask_nxt, mask_play;
    logic           brick_hit, in_brick;
`endif

    assign game_state = state;

    always_ff @(posedge CLK_25MH or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_SERVE;
            paddle_x   <= PAD_X0;
            ball_x     <= PAD_X0 + BALL_OFS[9:0];
            ball_y     <= SERVE_Y[9:0];
            dx_right   <= 1'b1;
            dy_up      <= 1'b1;
            lives      <= 2'(START_LIVES);
            score      <= 8'd0;
            lost_cnt   <= '0;
            serve_prev <= 1'b0;
            rgb_out    <= 3'b000;
`ifdef BRICKS_EN
            brick_mask <= 8'hFF;
`endif
        end else begin
            state      <= state_nxt;
            paddle_x   <= paddle_x_nxt;
            ball_x     <= ball_x_nxt;
            ball_y     <= ball_y_nxt;
            dx_right   <= dx_right_nxt;
            dy_up      <= dy_up_nxt;
            lives      <= lives_nxt;
            score      <= score_nxt;
            lost_cnt   <= lost_cnt_nxt;
            serve_prev <= serve_prev_nxt;
            rgb_out    <= rgb_nxt;
`ifdef BRICKS_EN
            brick_mask <= brick_mask_nxt;
`endif
        end
    end

    always_comb begin
        px         = {1'b0, paddle_x};
        bx         = {1'b0, ball_x};
        by         = {1'b0, ball_y};
        tick       = (hor_count == 10'd0) && (ver_count == 10'd480);
        serve_edge = btn_serve && !serve_prev;

        pad_mv = px;
        if (btn_left && !btn_right)
            pad_mv = (px < PAD_SP) ? 11'd0 : px - PAD_SP;
        else if (btn_right && !btn_left)
            pad_mv = (px + PAD_SP > PAD_MAX) ? PAD_MAX : px + PAD_SP;
        serve_x = pad_mv + BALL_OFS;

        // Hit test deliberately uses the pre-move paddle position.
        pad_hit = !dy_up && (by + BALL_W <= PAD_Y) && (by + BALL_SP + BALL_W >= PAD_Y)
                  && (bx + BALL_W > px) && (bx < px + PAD_W);
        miss    = !dy_up && !pad_hit && (by + BALL_SP >= SCR_H);

        nx      = bx;
        ny      = by;
        dx_play = dx_right;
        dy_play = dy_up;
        if (!dx_right) begin
            if (bx < BALL_SP) begin
                nx      = 11'd0;
                dx_play = 1'b1;
            end else
                nx = bx - BALL_SP;
        end else if (bx + BALL_SP > BALL_MAX) begin
            nx      = BALL_MAX;
            dx_play = 1'b0;
        end else
            nx = bx + BALL_SP;

        if (dy_up) begin
            if (by < BALL_SP) begin
                ny      = 11'd0;
                dy_play = 1'b0;
            end else
                ny = by - BALL_SP;
        end else if (pad_hit) begin
            ny      = SERVE_Y;
            dy_play = 1'b1;
        end else if (!miss)
            ny = by + BALL_SP;

`ifdef BRICKS_EN
        brick_hit = 1'b0;
        mask_play = brick_mask;
        for (int i = 0; i < 8; i++) begin
            if (!brick_hit && !miss && brick_mask[i] && (nx < 11'(80 * i + 80)) && (nx + BALL_W > 11'(80 * i))
                && (ny < 11'd48) && (ny + BALL_W > 11'd32)) begin
                brick_hit    = 1'b1;
                mask_play[i] = 1'b0;
            end
        end
        if (brick_hit)
            dy_play = !dy_play;
        brick_mask_nxt = brick_mask;
`endif

        state_nxt      = state;
        paddle_x_nxt   = paddle_x;
        ball_x_nxt     = ball_x;
        ball_y_nxt     = ball_y;
        dx_right_nxt   = dx_right;
        dy_up_nxt      = dy_up;
        lives_nxt      = lives;
        score_nxt      = score;
        lost_cnt_nxt   = lost_cnt;
        serve_prev_nxt = serve_prev;

        if (tick) begin
            serve_prev_nxt = btn_serve;
            if (state != ST_OVER)
                paddle_x_nxt = pad_mv[9:0];
`ifdef BRICKS_EN
            if (brick_mask == 8'h00)
                brick_mask_nxt = 8'hFF;
            else if (state == ST_PLAY)
                brick_mask_nxt = mask_play;
`endif
            case (state)
                ST_SERVE: begin
                    ball_x_nxt = serve_x[9:0];
                    ball_y_nxt = SERVE_Y[9:0];
                    if (serve_edge) begin
                        state_nxt    = ST_PLAY;
                        dx_right_nxt = 1'b1;
                        dy_up_nxt    = 1'b1;
                    end
                end
                ST_PLAY: begin
                    ball_x_nxt   = nx[9:0];
                    ball_y_nxt   = ny[9:0];
                    dx_right_nxt = dx_play;
                    dy_up_nxt    = dy_play;
                    if (miss) begin
                        state_nxt    = ST_LOST;
                        lost_cnt_nxt = '0;
                        lives_nxt    = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                    end
`ifdef BRICKS_EN
                    if (brick_hit && score != 8'hFF)
                        score_nxt = score + 8'd1;
`else
                    if (pad_hit && score != 8'hFF)
                        score_nxt = score + 8'd1;
`endif
                end
                ST_LOST: begin
                    if (lost_cnt == LOST_LAST) begin
                        lost_cnt_nxt = '0;
                        if (lives == 2'd0)
                            state_nxt = ST_OVER;
                        else begin
                            state_nxt  = ST_SERVE;
                            ball_x_nxt = serve_x[9:0];
                            ball_y_nxt = SERVE_Y[9:0];
                        end
                    end else
                        lost_cnt_nxt = lost_cnt + LCW'(1);
                end
                default: begin
                    if (serve_edge) begin
                        state_nxt    = ST_SERVE;
                        lives_nxt    = 2'(START_LIVES);
                        score_nxt    = 8'd0;
                        paddle_x_nxt = PAD_X0;
                        ball_x_nxt   = PAD_X0 + BALL_OFS[9:0];
                        ball_y_nxt   = SERVE_Y[9:0];
                        dx_right_nxt = 1'b1;
                        dy_up_nxt    = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        hx      = {1'b0, hor_count};
        vy      = {1'b0, ver_count};
        in_ball = (state != ST_LOST) && (hx >= bx) && (hx < bx + BALL_W) && (vy >= by) && (vy < by + BALL_W);
        in_pad  = (hx >= px) && (hx < px + PAD_W) && (vy >= PAD_Y) && (vy < PAD_Y + 11'd8);
`ifdef BRICKS_EN
        in_brick = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (brick_mask[i] && (hx >= 11'(80 * i)) && (hx < 11'(80 * i + 80)) && (vy >= 11'd32) && (vy < 11'd48))
                in_brick = 1'b1;
        end
`endif
        rgb_nxt = 3'b000;
        if ((hx < SCR_W) && (vy < SCR_H)) begin
            if (state == ST_OVER)
                rgb_nxt = 3'b100;
            else if (in_ball)
                rgb_nxt = 3'b111;
            else if (in_pad)
                rgb_nxt = 3'b110;
`ifdef BRICKS_EN
            else if (in_brick)
                rgb_nxt = 3'b010;
`endif
            else
                rgb_nxt = 3'b001;
        end
    end
endmodule

// File: tb/tb_breakout_renderer.sv
// Directed bench for breakout_renderer: frame ticks are injected directly rather than scanning a full raster.
module tb_breakout_renderer;
    logic       CLK_25MH;
    logic       rst_n;
    logic [9:0] hor_count;
    logic [9:0] ver_count;
    logic       btn_left;
    logic       btn_right;
    logic       btn_serve;
    logic [2:0] rgb_out;
    logic [1:0] lives;
    logic [7:0] score;
    logic [1:0] game_state;

    int checks = 0;
    int errors = 0;

    breakout_renderer dut (
        .CLK_25MH  (CLK_25MH),
        .rst_n     (rst_n),
        .hor_count (hor_count),
        .ver_count (ver_count),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_serve (btn_serve),
        .rgb_out   (rgb_out),
        .lives     (lives),
        .score     (score),
        .game_state(game_state)
    );

    initial CLK_25MH = 1'b0;
    always #20 CLK_25MH = ~CLK_25MH;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_tick(input logic l, input logic r, input logic s);
        @(negedge CLK_25MH);
        btn_left  = l;
        btn_right = r;
        btn_serve = s;
        hor_count = 10'd0;
        ver_count = 10'd480;
        @(negedge CLK_25MH);
        hor_count = 10'd700;
        ver_count = 10'd100;
    endtask

    task automatic ticks(input int n, input logic l, input logic r, input logic s);
        for (int i = 0; i < n; i++)
            do_tick(l, r, s);
    endtask

    task automatic check_px(input string tag, input int h, input int v, input int exp);
        @(negedge CLK_25MH);
        hor_count = 10'(h);
        ver_count = 10'(v);
        @(negedge CLK_25MH);
        check(tag, int'(rgb_out), exp);
        hor_count = 10'd700;
        ver_count = 10'd100;
    endtask

    task automatic check_ball(input string tag, input int x, input int y);
        check({tag, "_x"}, int'(dut.ball_x), x);
        check({tag, "_y"}, int'(dut.ball_y), y);
    endtask

    initial begin
        rst_n     = 1'b0;
        hor_count = 10'd700;
        ver_count = 10'd100;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_serve = 1'b0;
        repeat (3) @(negedge CLK_25MH);
        check("rst_rgb", int'(rgb_out), 0);
        rst_n = 1'b1;

        // Reset picture and outputs
        check("rst_lives", int'(lives), 3);
        check("rst_score", int'(score), 0);
        check("rst_state", int'(game_state), 0);
        check_px("px_paddle", 320, 452, 6);
        check_px("px_ball", 316, 440, 7);
        check_px("px_blank", 700, 100, 0);
        check_px("px_bg", 100, 100, 1);
        check_px("px_pad_left_out", 287, 452, 1);
        check_px("px_pad_right_out", 352, 452, 1);
        check_px("px_pad_corner", 351, 455, 6);

        // Paddle movement and clamping in SERVE, ball follows
        ticks(1, 1'b1, 1'b0, 1'b0);
        check("pad_l1", int'(dut.paddle_x), 284);
        check_ball("serve_track1", 312, 440);
        ticks(70, 1'b1, 1'b0, 1'b0);
        check("pad_l71", int'(dut.paddle_x), 4);
        ticks(1, 1'b1, 1'b0, 1'b0);
        check("pad_l72", int'(dut.paddle_x), 0);
        ticks(8, 1'b1, 1'b0, 1'b0);
        check("pad_l80", int'(dut.paddle_x), 0);
        check_ball("serve_track80", 28, 440);
        check("serve_state", int'(game_state), 0);
        ticks(2, 1'b0, 1'b1, 1'b0);
        check("pad_r2", int'(dut.paddle_x), 8);
        ticks(3, 1'b1, 1'b1, 1'b0);
        check("pad_both", int'(dut.paddle_x), 8);
        ticks(2, 1'b1, 1'b0, 1'b0);
        check("pad_back0", int'(dut.paddle_x), 0);
        check_px("px_pad_x0", 0, 448, 6);
        check_px("px_pad_x63", 63, 455, 6);
        check_px("px_pad_x64", 64, 450, 1);
        check_px("px_ball_tl", 28, 440, 7);
        check_px("px_ball_br_out", 36, 447, 1);

`ifdef BRICKS_EN
        // First brick: ball from x=28 meets brick 5 when next y is 46
        ticks(1, 1'b0, 1'b0, 1'b1);
        check("brk_state", int'(game_state), 1);
        ticks(196, 1'b0, 1'b0, 1'b0);
        check("brk_score0", int'(score), 0);
        check("brk_mask0", int'(dut.brick_mask), 8'hFF);
        check_ball("brk_pre", 420, 48);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check("brk_score1", int'(score), 1);
        check("brk_mask1", int'(dut.brick_mask), 8'hDF);
        check("brk_y_hit", int'(dut.ball_y), 46);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check("brk_y_down", int'(dut.ball_y), 48);
        check_px("px_brick0", 0, 32, 2);
        check_px("px_brick5_gone", 400, 40, 1);
`else
        // Serve from paddle 0: top wall at t=221, right wall at t=303, miss at t=461
        ticks(1, 1'b0, 1'b0, 1'b1);
        check("c_state_play", int'(game_state), 1);
        check_ball("c_t0", 28, 440);
        ticks(220, 1'b0, 1'b0, 1'b0);
        check_ball("c_t220", 468, 0);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check("c_t221_y", int'(dut.ball_y), 0);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check_ball("c_t222", 472, 2);
        ticks(80, 1'b0, 1'b0, 1'b0);
        check_ball("c_t302", 632, 162);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check_ball("c_t303", 632, 164);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check_ball("c_t304", 630, 166);
        ticks(156, 1'b0, 1'b0, 1'b0);
        check_ball("c_t460", 318, 478);
        check("c_t460_state", int'(game_state), 1);
        check_px("px_ball_low", 318, 478, 7);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check("c_miss_state", int'(game_state), 2);
        check("c_miss_lives", int'(lives), 2);
        check_px("px_ball_hidden", 316, 478, 1);
        ticks(31, 1'b0, 1'b0, 1'b0);
        check("c_lost31", int'(game_state), 2);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check("c_lost32", int'(game_state), 0);
        check("c_lives_after", int'(lives), 2);
        check_ball("c_reserve", 28, 440);

        // Serve from centre with serve held high, then paddle hit at t=441
        ticks(72, 1'b0, 1'b1, 1'b0);
        check("d_pad288", int'(dut.paddle_x), 288);
        ticks(1, 1'b0, 1'b0, 1'b1);
        ticks(10, 1'b1, 1'b0, 1'b1);
        check("d_state", int'(game_state), 1);
        check_ball("d_t10", 336, 420);
        check("d_pad_play", int'(dut.paddle_x), 248);
        check_px("px_d_ball", 336, 420, 7);
        check_px("px_d_left_out", 335, 420, 1);
        check_px("px_d_corner", 343, 427, 7);
        check_px("px_d_right_out", 344, 427, 1);
        ticks(50, 1'b1, 1'b0, 1'b0);
        check("d_pad48", int'(dut.paddle_x), 48);
        ticks(380, 1'b0, 1'b0, 1'b0);
        check("d_score0", int'(score), 0);
        check_ball("d_t440", 70, 438);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check("d_score1", int'(score), 1);
        check_ball("d_t441", 68, 440);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check_ball("d_t442", 66, 438);
`endif

        // Asynchronous reset in the middle of a line during PLAY
        @(negedge CLK_25MH);
        hor_count = 10'd600;
        ver_count = 10'd300;
        @(negedge CLK_25MH);
        check("pre_rst_rgb", int'(rgb_out), 1);
        #7 rst_n = 1'b0;
        #1;
        check("arst_rgb", int'(rgb_out), 0);
        check("arst_lives", int'(lives), 3);
        check("arst_score", int'(score), 0);
        check("arst_state", int'(game_state), 0);
        check("arst_pad", int'(dut.paddle_x), 288);
        check_ball("arst_ball", 316, 440);
        @(negedge CLK_25MH);
        rst_n     = 1'b1;
        hor_count = 10'd700;
        ver_count = 10'd100;

`ifndef BRICKS_EN
        // Three misses from centre serve lead to OVER
        for (int k = 1; k <= 3; k++) begin
            ticks(1, 1'b0, 1'b0, 1'b1);
            ticks(461, 1'b0, 1'b0, 1'b0);
            check("f_lost_state", int'(game_state), 2);
            check("f_lives", int'(lives), 3 - k);
            ticks(32, 1'b0, 1'b0, 1'b0);
            check("f_after_lost", int'(game_state), (k < 3) ? 0 : 3);
        end
        check("f_score", int'(score), 0);
        check_px("px_over_bg", 100, 100, 4);
        check_px("px_over_pad", 320, 452, 4);
        check_px("px_over_corner", 639, 479, 4);
        check_px("px_over_hblank", 640, 100, 0);
        check_px("px_over_vblank", 100, 480, 0);
        ticks(1, 1'b1, 1'b0, 1'b0);
        check("over_pad_frozen", int'(dut.paddle_x), 288);
        check("over_stays", int'(game_state), 3);
        ticks(1, 1'b0, 1'b0, 1'b1);
        check("restart_state", int'(game_state), 0);
        check("restart_lives", int'(lives), 3);
        check("restart_score", int'(score), 0);
        check("restart_pad", int'(dut.paddle_x), 288);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
